// File: rtl/divsi_shared_arbiter_pkg.sv
// Shared constants and helpers for the divsi shared-divider arbiter.
// Tag width is derived from the requester count, with a floor of one bit.
package divsi_arb_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

  // A single requester still carries a 1-bit (constant zero) tag.
  function automatic int unsigned tag_width(input int unsigned num_req);
    int unsigned w;
    w = clog2(num_req);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/divsi_shared_arbiter_if.sv
// Requester-side and divider-side signals of the shared divider arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface divsi_shared_arbiter_if #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned DATA_TYPE = 32
);
  logic [NUM_REQ*DATA_TYPE-1:0] ins_lhs;
  logic [NUM_REQ*DATA_TYPE-1:0] ins_rhs;
  logic [NUM_REQ-1:0]           ins_valid;
  logic [NUM_REQ-1:0]           ins_ready;
  logic [NUM_REQ*DATA_TYPE-1:0] outs;
  logic [NUM_REQ-1:0]           outs_valid;
  logic [NUM_REQ-1:0]           outs_ready;
  logic                         div_ce;
  logic [DATA_TYPE-1:0]         div_din0;
  logic [DATA_TYPE-1:0]         div_din1;
  logic [DATA_TYPE-1:0]         div_dout;

  modport slave (
    input  ins_lhs, ins_rhs, ins_valid, outs_ready, div_dout,
    output ins_ready, outs, outs_valid, div_ce, div_din0, div_din1
  );

  modport master (
    output ins_lhs, ins_rhs, ins_valid, outs_ready, div_dout,
    input  ins_ready, outs, outs_valid, div_ce, div_din0, div_din1
  );
endinterface

// File: rtl/divsi_shared_arbiter_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps.
// The pointer moves past the winner only when a grant is actually taken.
module rr_arbiter
  import divsi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned TagW   = tag_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [TagW-1:0]    grant_idx,
  output logic               any
);

  logic [TagW-1:0]      ptr_q, ptr_d;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic                 found;
  int                   off;
  int                   sum;
  int                   nxt;

  // Rotating a doubled copy puts the pointer's requester at bit 0.
  always_comb begin
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[NUM_REQ-1:0];
    found   = 1'b0;
    off     = 0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    sum = int'(ptr_q) + off;
    if (sum >= int'(NUM_REQ)) begin
      sum = sum - int'(NUM_REQ);
    end
    nxt = sum + 1;
    if (nxt >= int'(NUM_REQ)) begin
      nxt = 0;
    end
  end

  always_comb begin
    any          = |req;
    grant_idx    = TagW'(sum);
    grant_onehot = '0;
    for (int j = 0; j < int'(NUM_REQ); j++) begin
      grant_onehot[j] = found && (j == sum);
    end
    ptr_d = TagW'(nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en && any) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/divsi_shared_arbiter.sv
// Shares one pipelined signed divider between NUM_REQ requesters; a valid/tag
// shadow pipeline, stepped in lockstep with the divider, routes each quotient home.
module divsi_shared_arbiter
  import divsi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned DATA_TYPE = 32,
  parameter int unsigned LATENCY   = 36
) (
  input logic                   clk,
  input logic                   rst,
  divsi_shared_arbiter_if.slave bus
);

  localparam int unsigned TagW = tag_width(NUM_REQ);
  localparam int unsigned Tail = LATENCY - 1;

  logic [LATENCY-1:0]   vld_q;
  logic [TagW-1:0]      tag_q [LATENCY];
  logic [TagW-1:0]      hold_idx_q;

  logic [NUM_REQ-1:0]   grant_onehot;
  logic [TagW-1:0]      grant_idx;
  logic [TagW-1:0]      sel_idx;
  logic                 any;
  logic                 tail_ready;
  logic                 ce;
  logic                 fire;
  logic [DATA_TYPE-1:0] din0;
  logic [DATA_TYPE-1:0] din1;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.ins_valid),
    .en          (ce),
    .grant_onehot(grant_onehot),
    .grant_idx   (grant_idx),
    .any         (any)
  );

  always_comb begin
    tail_ready = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (tag_q[Tail] == TagW'(i)) begin
        tail_ready = bus.outs_ready[i];
      end
    end
  end

  // The whole pipeline freezes only while an unaccepted result sits at the tail.
  always_comb begin
    ce   = rst | ~vld_q[Tail] | tail_ready;
    fire = ce & any & ~rst;
  end

  // With no request, keep presenting the last winner's operands so din is stable.
  always_comb begin
    sel_idx = any ? grant_idx : hold_idx_q;
    din0    = bus.ins_lhs[DATA_TYPE-1:0];
    din1    = bus.ins_rhs[DATA_TYPE-1:0];
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (sel_idx == TagW'(i)) begin
        din0 = bus.ins_lhs[i*DATA_TYPE +: DATA_TYPE];
        din1 = bus.ins_rhs[i*DATA_TYPE +: DATA_TYPE];
      end
    end
  end

  always_comb begin
    bus.outs_valid = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      bus.outs_valid[i] = ~rst & vld_q[Tail] & (tag_q[Tail] == TagW'(i));
    end
  end

  assign bus.ins_ready = (ce & ~rst) ? grant_onehot : '0;
  assign bus.outs      = {NUM_REQ{bus.div_dout}};
  assign bus.div_ce    = ce;
  assign bus.div_din0  = din0;
  assign bus.div_din1  = din1;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_idx_q <= '0;
    end else if (any) begin
      hold_idx_q <= grant_idx;
    end
  end

  // Bubbles shift like real entries so tags stay aligned with div_dout.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
        tag_q[i] <= '0;
      end
    end else if (ce) begin
      vld_q[0] <= fire;
      tag_q[0] <= grant_idx;
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

endmodule

// File: doc/divsi_shared_arbiter.md
Name: divsi_shared_arbiter

Overview:
- Shares one pipelined signed-divider instance between NUM_REQ dataflow requesters.
- Round-robin arbitration picks one operand pair per cycle and drives the divider's din/ce.
- A valid/tag shadow pipeline aligned with the divider returns each quotient to the requester that issued it.
- Sits between several divsi-style elastic consumers and a single shared sdiv core; the core itself is external.

Parameters:
- NUM_REQ, 2, number of requesters (≥1).
- DATA_TYPE, 32, operand/result width.
- LATENCY, 36, divider latency in ce-enabled clock edges (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ins_lhs  in  NUM_REQ*DATA_TYPE  dividends, requester i at slice [i*DATA_TYPE +: DATA_TYPE]
- ins_rhs  in  NUM_REQ*DATA_TYPE  divisors, same packing
- ins_valid  in  NUM_REQ  operand pair valid (lhs/rhs joined upstream)
- ins_ready  out  NUM_REQ  operand pair accepted
- outs  out  NUM_REQ*DATA_TYPE  quotient per requester
- outs_valid  out  NUM_REQ  quotient valid
- outs_ready  in  NUM_REQ  consumer ready
- div_ce  out  1  divider clock enable
- div_din0  out  DATA_TYPE  divider dividend
- div_din1  out  DATA_TYPE  divider divisor
- div_dout  in  DATA_TYPE  divider quotient

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high. Reset clears all shadow valids and sets the RR pointer to 0.
- Outputs during and immediately after reset: outs_valid=0, ins_ready=0. div_ce=1, since the pipeline is empty.
- Shadow pipeline: vld[0..LATENCY-1], tag[0..LATENCY-1], tag width = max(1,clog2(NUM_REQ)).
  - Tail = index LATENCY-1; it is aligned with div_dout.
- Stall: div_ce = !vld[tail] || outs_ready[tag[tail]].
  - The shadow pipeline shifts only when div_ce=1, in lockstep with the divider.
  - Invalid slots (bubbles) shift as well; there is no bubble collapsing.
- Grant (combinational):
  - Search ins_valid starting at RR pointer p, wrapping modulo NUM_REQ. The first set bit is g.
  - ins_ready[g] = div_ce; all other ins_ready = 0.
  - fire = div_ce && any(ins_valid).
- Divider drive: div_din0/div_din1 = operands of g. With no valid request, hold the previous g's operands (don't-care, but stable).
- On fire: vld[0]<=1, tag[0]<=g, p <= (g+1) mod NUM_REQ.
- On div_ce && !fire: vld[0]<=0 and p is unchanged.
- When div_ce=0: nothing shifts, p holds, no grant.
- Result:
  - outs_valid[i] = vld[tail] && tag[tail]==i.
  - All outs slices = div_dout (broadcast; only the tagged requester sees valid).
  - Transfer completes when outs_ready[tag[tail]]=1; that same cycle div_ce=1, so the tail advances.
- Latency: operand accept → outs_valid asserted exactly LATENCY cycles later if never stalled. Each stall cycle adds one cycle.
- Throughput: one issue per cycle while unstalled.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 grants.
- Backpressure: a stalled tail freezes the whole pipeline. Other requesters' completed results wait behind it (head-of-line blocking).
- Divide by zero (rhs=0): the request is still issued, tagged, and returned. The quotient value is whatever the divider produces; no flag is raised.
- Signed arithmetic is the divider's concern (truncation toward zero). This block never inspects data.
- NUM_REQ=1: the arbiter degenerates to a pass-through; tag is a constant 0.
- Reset mid-operation: all in-flight requests are dropped and outs_valid falls at the next edge. The block never exposes a stale tail valid after reset.

Decomposition:
- Shared package divsi_arb_pkg:
  - clog2 helper function.
  - Tag-width constant function.
- Sub-module rr_arbiter:
  - Parameter NUM_REQ.
  - Ports: clk, rst, req[NUM_REQ], en, grant_onehot, grant_idx, any.
  - Owns the pointer; updates only when en && any.
- Top level holds the shadow shift register and the muxes.

Test Plan:
Bench setup: behavioral ce-gated LATENCY=4 signed divider model; NUM_REQ=2.
- Single issue: req0 sends 100/7 → outs_valid[0] rises exactly 4 cycles after accept, outs[0]=14, outs_valid[1] stays 0.
- Both requesters valid every cycle: req0 100/7, req1 -100/7 → grants alternate 0,1,0,1; req0 receives 14 and req1 receives -14, each in issue order.
- Tail stall: outs_ready[1]=0 for 3 cycles while a req1 result sits at tail → div_ce=0, ins_ready all 0, vld/tag frozen. Result completes on release; latency of the queued results grows by 3.
- Divide by zero: req0 sends 5/0 → exactly one outs_valid[0] pulse after 4 cycles, no hang.
- Reset mid-flight: 3 requests in flight, rst for 1 cycle → all outs_valid=0 next edge. No late results appear; next grant goes to req0.
- Bubbles: req0 issues at cycles 0 and 2 only → results at cycles 4 and 6, with outs_valid low at cycle 5.
